// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: single-outstanding request/ack bus.
//   dmem_req/we/addr/wdata/wstrb : request side, driven by the stage (master)
//   dmem_ack/rdata               : response side, driven by memory (slave)
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory access FSM, load
// sizing/extension and the MEM/WB register feeding writeback.
//   clk, rst          : clock, synchronous active-high reset
//   ex_*              : execute-stage bundle captured into M
//   jal_flush         : squash the instruction held in M
//   mem_stall         : freeze the front of the pipe while an access is pending
//   regD_mem/...      : forwarding taps from M
//   dmem              : data-memory request/ack port
//   regwrite..regdata : registered MEM/WB bundle
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_regwrite,
   input  logic        ex_jal,
   input  logic        ex_memread,
   input  logic        ex_memwrite,
   input  logic [4:0]  ex_regD,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu,
   input  logic [31:0] ex_store_data,
   input  logic [31:0] ex_target,
   input  logic        jal_flush,
   output logic        mem_stall,
   output logic [4:0]  regD_mem,
   output logic [31:0] regD_val_mem,
   output logic        regwrite_mem,
   mem_stage_if.master dmem,
   output logic        regwrite,
   output logic        jal,
   output logic [4:0]  regD,
   output logic [31:0] target,
   output logic [31:0] regdata
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            jal;
      logic            memread;
      logic            memwrite;
      logic [RW-1:0]   regd;
      logic [2:0]      funct3;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] store_data;
      logic [XLEN-1:0] target;
   } m_t;

   typedef struct packed {
      logic            regwrite;
      logic            jal;
      logic [RW-1:0]   regd;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] regdata;
   } wb_t;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   m_t              m_q, m_d;
   wb_t             wb_q, wb_d;
   logic            memop;
   logic            req;
   logic [XLEN-1:0] wdata;
   logic [3:0]      wstrb;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   // Request control; a flush only suppresses a request not yet issued.
   always_comb begin
      memop     = m_q.valid & (m_q.memread | m_q.memwrite);
      req       = memop & ~(jal_flush & (state_q == S_IDLE));
      mem_stall = memop & ~dmem.dmem_ack;
   end

   // Access FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (memop && req && !dmem.dmem_ack) state_d = S_WAIT;
         S_WAIT: if (dmem.dmem_ack)                  state_d = S_IDLE;
         default:                                    state_d = S_IDLE;
      endcase
   end

   // Store lane replication and byte strobes.
   always_comb begin
      wdata = m_q.store_data;
      wstrb = 4'b0000;
      case (m_q.funct3[1:0])
         2'b00: begin
            wdata = {4{m_q.store_data[7:0]}};
            wstrb = 4'b0001 << m_q.alu[1:0];
         end
         2'b01: begin
            wdata = {2{m_q.store_data[15:0]}};
            wstrb = m_q.alu[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = m_q.store_data;
            wstrb = 4'b1111;
         end
      endcase
      if (!m_q.memwrite) wstrb = 4'b0000;
   end

   // Load lane select and extension.
   always_comb begin
      ld_byte = 8'h00;
      case (m_q.alu[1:0])
         2'd0:    ld_byte = dmem.dmem_rdata[7:0];
         2'd1:    ld_byte = dmem.dmem_rdata[15:8];
         2'd2:    ld_byte = dmem.dmem_rdata[23:16];
         default: ld_byte = dmem.dmem_rdata[31:24];
      endcase
      ld_half = m_q.alu[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (m_q.funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h000000, ld_byte};
         3'b101:  ld_data = {16'h0000, ld_half};
         default: ld_data = dmem.dmem_rdata;
      endcase
   end

   // M register next value; flush wins over capture, stall holds.
   always_comb begin
      m_d = m_q;
      if (jal_flush) begin
         m_d = '0;
      end else if (!mem_stall) begin
         m_d.valid      = ex_valid;
         m_d.regwrite   = ex_regwrite;
         m_d.jal        = ex_jal;
         m_d.memread    = ex_memread;
         m_d.memwrite   = ex_memwrite;
         m_d.regd       = ex_regD;
         m_d.funct3     = ex_funct3;
         m_d.alu        = ex_alu;
         m_d.store_data = ex_store_data;
         m_d.target     = ex_target;
      end
   end

   // MEM/WB next value; bubbles during stalls and flushes.
   always_comb begin
      wb_d = '0;
      if (m_q.valid && !mem_stall && !jal_flush) begin
         wb_d.regwrite = m_q.regwrite;
         wb_d.jal      = m_q.jal;
         wb_d.regd     = m_q.regd;
         wb_d.target   = m_q.target;
         wb_d.regdata  = m_q.memread ? ld_data : m_q.alu;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = m_q.memwrite;
   assign dmem.dmem_addr  = {m_q.alu[31:2], 2'b00};
   assign dmem.dmem_wdata = wdata;
   assign dmem.dmem_wstrb = wstrb;

   // Loads are not forwarded from M; the hazard unit bubbles load-use.
   assign regD_mem     = m_q.regd;
   assign regD_val_mem = m_q.alu;
   assign regwrite_mem = m_q.valid & m_q.regwrite & ~m_q.memread;

   assign regwrite = wb_q.regwrite;
   assign jal      = wb_q.jal;
   assign regD     = wb_q.regd;
   assign target   = wb_q.target;
   assign regdata  = wb_q.regdata;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instructions checked against a behavioural model of the stage.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_regwrite, ex_jal, ex_memread, ex_memwrite;
   logic [4:0]  ex_regD;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu, ex_store_data, ex_target;
   logic        jal_flush;
   logic        mem_stall;
   logic [4:0]  regD_mem;
   logic [31:0] regD_val_mem;
   logic        regwrite_mem;
   logic        regwrite, jal;
   logic [4:0]  regD;
   logic [31:0] target, regdata;

   int tests = 0;
   int fails = 0;

   mem_stage_if dmem ();

   mem_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_jal(ex_jal),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regD(ex_regD), .ex_funct3(ex_funct3), .ex_alu(ex_alu),
      .ex_store_data(ex_store_data), .ex_target(ex_target),
      .jal_flush(jal_flush), .mem_stall(mem_stall),
      .regD_mem(regD_mem), .regD_val_mem(regD_val_mem),
      .regwrite_mem(regwrite_mem), .dmem(dmem.master),
      .regwrite(regwrite), .jal(jal), .regD(regD),
      .target(target), .regdata(regdata)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference rules written as plain arithmetic on the access fields.
   function automatic logic [31:0] exp_load(input int unsigned f3, input int unsigned a,
                                           input int unsigned rd);
      int unsigned b, h;
      b = (rd >> ((a % 4) * 8)) % 256;
      h = (rd >> (((a / 2) % 2) * 16)) % 65536;
      case (f3)
         0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         4:       return b;
         5:       return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] exp_wstrb(input int unsigned f3, input int unsigned a);
      case (f3)
         0:       return 32'(1 << (a % 4));
         1:       return ((a / 2) % 2 == 1) ? 32'd12 : 32'd3;
         default: return 32'd15;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input int unsigned f3, input int unsigned sd);
      case (f3)
         0:       return (sd % 256) * 32'h0101_0101;
         1:       return (sd % 65536) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   task automatic check_wb(input string tag, input logic rw, input logic jl,
                           input logic [4:0] rd, input logic [31:0] tg, input logic [31:0] dat);
      chk({tag, ".regwrite"}, 32'(regwrite), 32'(rw));
      chk({tag, ".jal"},      32'(jal),      32'(jl));
      chk({tag, ".regD"},     32'(regD),     32'(rd));
      chk({tag, ".target"},   32'(target),   tg);
      chk({tag, ".regdata"},  regdata,       dat);
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_regwrite = 0; ex_jal = 0; ex_memread = 0; ex_memwrite = 0;
      ex_regD = '0; ex_funct3 = '0; ex_alu = '0; ex_store_data = '0; ex_target = '0;
   endtask

   // kind: 0 = ALU/jal, 1 = load, 2 = store; k = cycles before ack.
   task automatic run_instr(input string tag, input int kind, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] tg, input logic [4:0] rd,
                            input logic rw, input logic jl,
                            input logic [31:0] rdata, input int k);
      logic [31:0] res;
      ex_valid = 1; ex_regwrite = rw; ex_jal = jl;
      ex_memread = (kind == 1); ex_memwrite = (kind == 2);
      ex_regD = rd; ex_funct3 = f3; ex_alu = a; ex_store_data = sd; ex_target = tg;
      @(posedge clk); #1;
      clear_ex();
      chk({tag, ".fwd_regD"}, 32'(regD_mem), 32'(rd));
      chk({tag, ".fwd_val"}, regD_val_mem, a);
      chk({tag, ".fwd_en"}, 32'(regwrite_mem), 32'(rw && kind != 1));
      res = (kind == 1) ? exp_load(f3, a, rdata) : a;
      if (kind == 0) begin
         #1;
         chk({tag, ".stall"}, 32'(mem_stall), 32'd0);
         chk({tag, ".req"}, 32'(dmem.dmem_req), 32'd0);
         @(posedge clk); #1;
      end else begin
         for (int c = 0; c <= k; c++) begin
            dmem.dmem_ack = (c == k);
            dmem.dmem_rdata = (c == k) ? rdata : 32'hDEAD_BEEF;
            #1;
            chk({tag, ".req"}, 32'(dmem.dmem_req), 32'd1);
            chk({tag, ".addr"}, dmem.dmem_addr, a & 32'hFFFF_FFFC);
            chk({tag, ".we"}, 32'(dmem.dmem_we), 32'(kind == 2));
            chk({tag, ".wstrb"}, 32'(dmem.dmem_wstrb), (kind == 2) ? exp_wstrb(f3, a) : 32'd0);
            if (kind == 2) chk({tag, ".wdata"}, dmem.dmem_wdata, exp_wdata(f3, sd));
            chk({tag, ".stall"}, 32'(mem_stall), 32'(c < k));
            @(posedge clk); #1;
            dmem.dmem_ack = 0;
            if (c < k) check_wb({tag, ".bubble"}, 0, 0, 5'd0, 32'd0, 32'd0);
         end
      end
      check_wb({tag, ".wb"}, rw, jl, rd, tg, res);
   endtask

   initial begin
      int kind, k;
      logic [2:0] f3;
      logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      clear_ex();
      rst = 1; jal_flush = 0;
      dmem.dmem_ack = 0; dmem.dmem_rdata = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", 32'(mem_stall), 32'd0);
      chk("rst.req", 32'(dmem.dmem_req), 32'd0);
      chk("rst.we", 32'(dmem.dmem_we), 32'd0);
      chk("rst.addr", dmem.dmem_addr, 32'd0);
      chk("rst.wdata", dmem.dmem_wdata, 32'd0);
      chk("rst.wstrb", 32'(dmem.dmem_wstrb), 32'd0);
      chk("rst.fwd_en", 32'(regwrite_mem), 32'd0);
      chk("rst.fwd_regD", 32'(regD_mem), 32'd0);
      chk("rst.fwd_val", regD_val_mem, 32'd0);
      check_wb("rst", 0, 0, 5'd0, 32'd0, 32'd0);
      rst = 0;

      // Directed cases.
      run_instr("add", 0, 3'd0, 32'h10, 32'd0, 32'd0, 5'd5, 1, 0, 32'd0, 0);
      run_instr("sb", 2, 3'd0, 32'h103, 32'hAB, 32'd0, 5'd0, 0, 0, 32'd0, 3);
      run_instr("lh", 1, 3'd1, 32'h202, 32'd0, 32'd0, 5'd1, 1, 0, 32'h80FF_1234, 1);
      run_instr("lhu", 1, 3'd5, 32'h202, 32'd0, 32'd0, 5'd2, 1, 0, 32'h80FF_1234, 2);
      run_instr("lb", 1, 3'd0, 32'h202, 32'd0, 32'd0, 5'd3, 1, 0, 32'h80FF_1234, 1);
      run_instr("lbu", 1, 3'd4, 32'h202, 32'd0, 32'd0, 5'd4, 1, 0, 32'h80FF_1234, 1);
      run_instr("lw", 1, 3'd2, 32'h202, 32'd0, 32'd0, 5'd6, 1, 0, 32'h80FF_1234, 1);
      run_instr("lw0", 1, 3'd2, 32'h400, 32'd0, 32'd0, 5'd7, 1, 0, 32'h1357_9BDF, 0);
      run_instr("sh_hi", 2, 3'd1, 32'h503, 32'hCAFE, 32'd0, 5'd0, 0, 0, 32'd0, 1);
      run_instr("sw", 2, 3'd2, 32'h607, 32'h1234_5678, 32'd0, 5'd0, 0, 0, 32'd0, 0);
      run_instr("jal", 0, 3'd0, 32'h0000_0104, 32'd0, 32'h0000_0800, 5'd1, 1, 1, 32'd0, 0);

      // Flush with a fresh store in M: no request, bubbles downstream.
      ex_valid = 1; ex_memwrite = 1; ex_regwrite = 1; ex_regD = 5'd9;
      ex_funct3 = 3'd2; ex_alu = 32'h300; ex_store_data = 32'h5555_AAAA; ex_target = 32'h44;
      @(posedge clk); #1;
      clear_ex();
      jal_flush = 1;
      #1;
      chk("flush.req", 32'(dmem.dmem_req), 32'd0);
      @(posedge clk); #1;
      jal_flush = 0;
      #1;
      check_wb("flush", 0, 0, 5'd0, 32'd0, 32'd0);
      chk("flush.req_after", 32'(dmem.dmem_req), 32'd0);
      chk("flush.fwd_en", 32'(regwrite_mem), 32'd0);

      // Randomized instructions against the model.
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 2));
         k = int'($urandom_range(0, 3));
         f3 = (kind == 1) ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         run_instr($sformatf("rnd%0d", i), kind, f3, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), (kind == 0) ? 1'($urandom) : 1'b0,
                   $urandom, k);
      end

      // Reset while an access is waiting: request must drop.
      ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_regD = 5'd3;
      ex_funct3 = 3'd2; ex_alu = 32'h700;
      @(posedge clk); #1;
      clear_ex();
      #1;
      chk("rstmid.req_before", 32'(dmem.dmem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      chk("rstmid.req", 32'(dmem.dmem_req), 32'd0);
      chk("rstmid.stall", 32'(mem_stall), 32'd0);
      check_wb("rstmid", 0, 0, 5'd0, 32'd0, 32'd0);
      rst = 0;
      run_instr("post_rst_lw", 1, 3'd0, 32'h801, 32'd0, 32'd0, 5'd8, 1, 0, 32'h0000_7F00, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
